saturn_phase_gen: RTL and testbench
===================================

# saturn_phase_gen

Parametrised multi-phase clock-enable generator with cycle counter, cycle-limit watchdog and run/halt/single-step control. It drives the one-hot phase enables consumed by the decoder, ALU and bus controller, and the cycle counter shared by their debug output. It also sources the core halt flag. The block generalises the fixed 4-phase rotator to N phases and adds stall hold, a debugger-driven halt and single-step, and a programmable cycle limit.

## Interface
Parameters:
- NUM_PHASES, 4, number of phases per machine cycle; must be ≥ 2.
- CTR_WIDTH, 32, width of the cycle counter and the limit register.
- MAX_CYCLE_DEFAULT, 125, limit value loaded at reset.
- PHASE_W, $clog2(NUM_PHASES), width of the phase index (derived).

Ports:
- i_clk, in, 1, sole clock. All state updates on its rising edge.
- i_reset, in, 1, synchronous, active-high reset.
- i_stall, in, 1, freezes phase rotation and the counter while high.
- i_halt_req, in, 1, requests a halt at the next cycle boundary.
- i_run, in, 1, leaves HALTED and enters free-running mode.
- i_step, in, 1, from HALTED, executes exactly one machine cycle.
- i_max_load, in, 1, loads i_max_value into the limit register.
- i_max_value, in, CTR_WIDTH, new limit value. All-ones disables the limit.
- o_phases, out, NUM_PHASES, one-hot phase enables; bit k means phase k.
- o_phase_idx, out, PHASE_W, binary index of the active phase.
- o_cycle_ctr, out, CTR_WIDTH, machine-cycle counter.
- o_running, out, 1, high when the state is RUN or STEP.
- o_halt, out, 1, high when the state is HALTED.
- o_halt_cause, out, 2, halt cause: 0 none, 1 limit, 2 request, 3 step.

## Operation
- States: RUN, STEP, HALTED.
- Reset values: state RUN, o_phases = 1 (phase 0), o_phase_idx 0, o_cycle_ctr all-ones, limit = MAX_CYCLE_DEFAULT, o_halt_cause 0, o_running 1, o_halt 0.
- Advance condition: adv = (state is RUN or STEP) and !i_stall.
- On adv, o_phases rotates left by one, and bit NUM_PHASES-1 wraps to bit 0. o_phase_idx increments modulo NUM_PHASES.
- On adv with o_phases[0] set, o_cycle_ctr increments by 1. The counter wraps from all-ones to 0 with no flag; the first post-reset phase-0 edge therefore yields 0.
- A boundary event is an edge where adv is high and the last phase is active; the next phase is phase 0.
- All halts take effect only at a boundary, so the phase enables always freeze at phase 0.
- RUN → HALTED at a boundary when either of these holds:
  - limit reached: limit ≠ all-ones and o_cycle_ctr == limit; cause 1.
  - halt request: i_halt_req is high on that edge, or was latched high since the last boundary; cause 2.
  - If both hold, cause 1 wins.
  - The pending request latch clears when the halt is taken.
- HALTED:
  - Phases and counter hold.
  - i_run → RUN; cause is cleared to 0.
  - Otherwise i_step → STEP.
  - If i_run and i_step are high together, i_run wins.
  - i_halt_req is ignored.
- STEP: runs exactly NUM_PHASES advances, with stalls extending the step. At its boundary it returns to HALTED with cause 3, or cause 1 if the limit condition also holds. i_halt_req is ignored during STEP.
- Limit equality is checked only at the boundary. After i_run from a limit halt, the counter moves past the limit and continues, with no re-halt until the counter wraps back to the limit.
- i_max_load is accepted in any state; the new limit applies from the next edge.
- i_reset mid-step or mid-cycle returns every output to its reset value on that edge, and clears any latched request.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- i_stall acts on the same edge: phases do not rotate on an edge where i_stall is high.
- Halt latency: o_halt rises on the boundary edge itself. On the following cycle o_phases = 1.
- i_run or i_step sampled in HALTED: o_running rises on that edge, and the first advance occurs on the next edge.
- Cycle period with no stall is NUM_PHASES clocks. Each stall clock extends it by one.

## Test plan
- Reset, then NUM_PHASES=4 with no stalls → o_phases sequence 0001, 0010, 0100, 1000, 0001. o_cycle_ctr becomes 0 after edge 1 and 1 after edge 5.
- Limit 3 loaded, free run → o_halt rises on edge 16 with o_cycle_ctr=3, o_phases=0001, cause 1. The outputs then hold for 20 idle clocks.
- i_stall held 3 clocks while in phase 2 → phase 2 persists for 4 clocks and the counter is unchanged. Rotation then resumes at phase 3.
- i_halt_req pulsed during phase 1 of cycle 5 → halt at the end of cycle 5 with cause 2. Then i_step → exactly 4 advances, ctr=6, cause 3.
- NUM_PHASES=6, CTR_WIDTH=4, limit all-ones → the counter wraps from 15 to 0 with no halt, and the period is 6 clocks.
- i_reset asserted mid-step at phase 2 → on that edge, o_phases=1, ctr all-ones, state RUN, cause 0.

Source files
------------

// File: rtl/saturn_phase_gen.sv
// rtl/saturn_phase_gen.sv - multi-phase clock-enable generator with cycle counter, limit watchdog and run/halt/step control
// Halts are only taken at a machine-cycle boundary so the enables always freeze on phase 0.
module saturn_phase_gen #(
  parameter int          NUM_PHASES        = 4,
  parameter int          CTR_WIDTH         = 32,
  parameter int unsigned MAX_CYCLE_DEFAULT = 125,
  parameter int          PHASE_W           = $clog2(NUM_PHASES)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_halt_req,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_max_load,
  input  logic [CTR_WIDTH-1:0]  i_max_value,
  output logic [NUM_PHASES-1:0] o_phases,
  output logic [PHASE_W-1:0]    o_phase_idx,
  output logic [CTR_WIDTH-1:0]  o_cycle_ctr,
  output logic                  o_running,
  output logic                  o_halt,
  output logic [1:0]            o_halt_cause
);

  if (NUM_PHASES < 2) begin : g_bad_phases
    $error("saturn_phase_gen: NUM_PHASES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STEP   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_REQ   = 2'd2;
  localparam logic [1:0] CAUSE_STEP  = 2'd3;

  localparam logic [PHASE_W-1:0]    LAST_IDX  = PHASE_W'(NUM_PHASES - 1);
  localparam logic [CTR_WIDTH-1:0]  LIMIT_RST = CTR_WIDTH'(MAX_CYCLE_DEFAULT);
  localparam logic [NUM_PHASES-1:0] PHASE0    = NUM_PHASES'(1);

  state_t                  state_q, state_d;
  logic [NUM_PHASES-1:0]   phases_q;
  logic [PHASE_W-1:0]      idx_q;
  logic [CTR_WIDTH-1:0]    ctr_q;
  logic [CTR_WIDTH-1:0]    limit_q;
  logic [1:0]              cause_q, cause_d;
  logic                    req_pend_q, req_pend_d;
  logic                    adv;
  logic                    boundary;
  logic                    limit_hit;

  always_comb begin
    adv        = (state_q != ST_HALTED) && !i_stall;
    boundary   = adv && phases_q[NUM_PHASES-1];
    // An all-ones limit disables the watchdog.
    limit_hit  = (limit_q != {CTR_WIDTH{1'b1}}) && (ctr_q == limit_q);
    state_d    = state_q;
    cause_d    = cause_q;
    req_pend_d = req_pend_q;

    case (state_q)
      ST_RUN: begin
        if (i_halt_req) begin
          req_pend_d = 1'b1;
        end
        if (boundary && limit_hit) begin
          state_d    = ST_HALTED;
          cause_d    = CAUSE_LIMIT;
          req_pend_d = 1'b0;
        end else if (boundary && (i_halt_req || req_pend_q)) begin
          state_d    = ST_HALTED;
          cause_d    = CAUSE_REQ;
          req_pend_d = 1'b0;
        end
      end
      ST_STEP: begin
        if (boundary) begin
          state_d = ST_HALTED;
          cause_d = limit_hit ? CAUSE_LIMIT : CAUSE_STEP;
        end
      end
      ST_HALTED: begin
        if (i_run) begin
          state_d = ST_RUN;
          cause_d = CAUSE_NONE;
        end else if (i_step) begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = ST_RUN;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_RUN;
      cause_q    <= CAUSE_NONE;
      req_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      req_pend_q <= req_pend_d;
    end
  end

  // Counter starts at all-ones so the first phase-0 advance after reset reads 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phases_q <= PHASE0;
      idx_q    <= '0;
      ctr_q    <= {CTR_WIDTH{1'b1}};
      limit_q  <= LIMIT_RST;
    end else begin
      if (adv) begin
        phases_q <= {phases_q[NUM_PHASES-2:0], phases_q[NUM_PHASES-1]};
        idx_q    <= (idx_q == LAST_IDX) ? '0 : idx_q + PHASE_W'(1);
        if (phases_q[0]) begin
          ctr_q <= ctr_q + CTR_WIDTH'(1);
        end
      end
      if (i_max_load) begin
        limit_q <= i_max_value;
      end
    end
  end

  assign o_phases     = phases_q;
  assign o_phase_idx  = idx_q;
  assign o_cycle_ctr  = ctr_q;
  assign o_running    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_halt       = (state_q == ST_HALTED);
  assign o_halt_cause = cause_q;

endmodule

// File: tb/tb_saturn_phase_gen.sv
// tb/tb_saturn_phase_gen.sv - scoreboard bench for saturn_phase_gen (4-phase/32-bit and 6-phase/4-bit instances)
module tb_saturn_phase_gen;

  logic        clk = 1'b0;
  logic        rst1, rst6;
  logic        stall, hreq, run, step, mload;
  logic [31:0] mval;

  logic [3:0]  ph1;
  logic [1:0]  idx1;
  logic [31:0] ctr1;
  logic        running1, halt1;
  logic [1:0]  cause1;

  logic [5:0]  ph6;
  logic [2:0]  idx6;
  logic [3:0]  ctr6;
  logic        running6, halt6;
  logic [1:0]  cause6;

  always #5 clk = ~clk;

  saturn_phase_gen #(.NUM_PHASES(4), .CTR_WIDTH(32), .MAX_CYCLE_DEFAULT(125)) u_dut4 (
    .i_clk(clk), .i_reset(rst1), .i_stall(stall), .i_halt_req(hreq), .i_run(run),
    .i_step(step), .i_max_load(mload), .i_max_value(mval),
    .o_phases(ph1), .o_phase_idx(idx1), .o_cycle_ctr(ctr1), .o_running(running1),
    .o_halt(halt1), .o_halt_cause(cause1)
  );

  saturn_phase_gen #(.NUM_PHASES(6), .CTR_WIDTH(4), .MAX_CYCLE_DEFAULT(15)) u_dut6 (
    .i_clk(clk), .i_reset(rst6), .i_stall(1'b0), .i_halt_req(1'b0), .i_run(1'b0),
    .i_step(1'b0), .i_max_load(1'b0), .i_max_value(4'd0),
    .o_phases(ph6), .o_phase_idx(idx6), .o_cycle_ctr(ctr6), .o_running(running6),
    .o_halt(halt6), .o_halt_cause(cause6)
  );

  typedef struct {
    int          cyc;
    int          dut;
    logic [7:0]  ph;
    logic [2:0]  idx;
    logic [31:0] ctr;
    logic        run;
    logic        hlt;
    logic [1:0]  cause;
    bit          chk_cause;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string nm, input int dut, input logic [7:0] ph, input logic [2:0] idx,
                      input logic [31:0] ctr, input logic r, input logic h, input logic [1:0] c,
                      input bit chk_c);
    exp_t e;
    e.cyc = cyc + 1; e.dut = dut; e.ph = ph; e.idx = idx; e.ctr = ctr;
    e.run = r; e.hlt = h; e.cause = c; e.chk_cause = chk_c; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Edge e after reset release of the 4-phase instance in free run.
  task automatic run_free(input int e_from, input int e_to);
    for (int e = e_from; e <= e_to; e++) begin
      push("free_run", 1, 8'd1 << (e % 4), 3'(e % 4), 32'((e - 1) / 4), 1'b1, 1'b0, 2'd0, 1'b1);
      tick();
    end
  endtask

  task automatic reset_dut4();
    rst1 = 1'b1;
    push("reset", 1, 8'h01, 3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd0, 1'b1);
    tick();
    rst1 = 1'b0;
  endtask

  // Monitor: compares every expectation tagged for the edge just taken.
  initial begin
    exp_t        e;
    logic [7:0]  a_ph;
    logic [2:0]  a_idx;
    logic [31:0] a_ctr;
    logic        a_run, a_hlt;
    logic [1:0]  a_cause;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.dut == 1) begin
          a_ph = {4'b0, ph1}; a_idx = {1'b0, idx1}; a_ctr = ctr1;
          a_run = running1; a_hlt = halt1; a_cause = cause1;
        end else begin
          a_ph = {2'b0, ph6}; a_idx = idx6; a_ctr = {28'b0, ctr6};
          a_run = running6; a_hlt = halt6; a_cause = cause6;
        end
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s stale expectation: cycle %0d required, checked at %0d", e.nm, e.cyc, cyc);
        end else if (a_ph !== e.ph || a_idx !== e.idx || a_ctr !== e.ctr || a_run !== e.run ||
                     a_hlt !== e.hlt || (e.chk_cause && a_cause !== e.cause)) begin
          errors++;
          $display("FAIL %s cyc %0d dut%0d: got ph=%h idx=%0d ctr=%h run=%b halt=%b cause=%0d, want ph=%h idx=%0d ctr=%h run=%b halt=%b cause=%0d",
                   e.nm, cyc, e.dut, a_ph, a_idx, a_ctr, a_run, a_hlt, a_cause,
                   e.ph, e.idx, e.ctr, e.run, e.hlt, e.cause);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst1 = 1'b1; rst6 = 1'b1;
    stall = 1'b0; hreq = 1'b0; run = 1'b0; step = 1'b0; mload = 1'b0; mval = 32'd0;
    repeat (2) tick();

    // Reset and basic rotation: ctr 0 after edge 1, 1 after edge 5.
    reset_dut4();
    run_free(1, 9);

    // Limit 3: halt on edge 16 with ctr 3, then hold for 20 clocks.
    reset_dut4();
    mload = 1'b1; mval = 32'd3;
    run_free(1, 1);
    mload = 1'b0;
    run_free(2, 15);
    push("limit_halt", 1, 8'h01, 3'd0, 32'd3, 1'b0, 1'b1, 2'd1, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      push("limit_hold", 1, 8'h01, 3'd0, 32'd3, 1'b0, 1'b1, 2'd1, 1'b1);
      tick();
    end
    // run and step together: run wins, cause cleared, first advance next edge.
    run = 1'b1; step = 1'b1;
    push("run_wins", 1, 8'h01, 3'd0, 32'd3, 1'b1, 1'b0, 2'd0, 1'b1);
    tick();
    run = 1'b0; step = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      push("past_limit", 1, 8'd1 << (k % 4), 3'(k % 4), 32'(3 + (k + 3) / 4), 1'b1, 1'b0, 2'd0, 1'b1);
      tick();
    end

    // Stall for 3 clocks in phase 2.
    reset_dut4();
    run_free(1, 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("stall_hold", 1, 8'h04, 3'd2, 32'd0, 1'b1, 1'b0, 2'd0, 1'b1);
      tick();
    end
    stall = 1'b0;
    push("stall_resume", 1, 8'h08, 3'd3, 32'd0, 1'b1, 1'b0, 2'd0, 1'b1); tick();
    push("stall_resume", 1, 8'h01, 3'd0, 32'd0, 1'b1, 1'b0, 2'd0, 1'b1); tick();
    push("stall_resume", 1, 8'h02, 3'd1, 32'd1, 1'b1, 1'b0, 2'd0, 1'b1); tick();

    // Halt request pulsed in phase 1 of the ctr=5 cycle.
    reset_dut4();
    run_free(1, 21);
    hreq = 1'b1;
    push("req_pending", 1, 8'h04, 3'd2, 32'd5, 1'b1, 1'b0, 2'd0, 1'b1); tick();
    hreq = 1'b0;
    push("req_pending", 1, 8'h08, 3'd3, 32'd5, 1'b1, 1'b0, 2'd0, 1'b1); tick();
    push("req_halt", 1, 8'h01, 3'd0, 32'd5, 1'b0, 1'b1, 2'd2, 1'b1); tick();
    hreq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push("req_ignored_halted", 1, 8'h01, 3'd0, 32'd5, 1'b0, 1'b1, 2'd2, 1'b1);
      tick();
    end
    step = 1'b1;
    push("step_enter", 1, 8'h01, 3'd0, 32'd5, 1'b1, 1'b0, 2'd0, 1'b0); tick();
    step = 1'b0;
    push("step_adv", 1, 8'h02, 3'd1, 32'd6, 1'b1, 1'b0, 2'd0, 1'b0); tick();
    push("step_adv", 1, 8'h04, 3'd2, 32'd6, 1'b1, 1'b0, 2'd0, 1'b0); tick();
    push("step_adv", 1, 8'h08, 3'd3, 32'd6, 1'b1, 1'b0, 2'd0, 1'b0); tick();
    push("step_done", 1, 8'h01, 3'd0, 32'd6, 1'b0, 1'b1, 2'd3, 1'b1); tick();
    hreq = 1'b0;
    push("step_hold", 1, 8'h01, 3'd0, 32'd6, 1'b0, 1'b1, 2'd3, 1'b1); tick();

    // Reset in the middle of a step at phase 2.
    step = 1'b1;
    push("step2_enter", 1, 8'h01, 3'd0, 32'd6, 1'b1, 1'b0, 2'd0, 1'b0); tick();
    step = 1'b0;
    push("step2_adv", 1, 8'h02, 3'd1, 32'd7, 1'b1, 1'b0, 2'd0, 1'b0); tick();
    push("step2_adv", 1, 8'h04, 3'd2, 32'd7, 1'b1, 1'b0, 2'd0, 1'b0); tick();
    reset_dut4();
    run_free(1, 8);

    // 6-phase, 4-bit counter, limit disabled: wraps 15 -> 0 with no halt.
    rst6 = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      push("wrap6", 6, 8'd1 << (e % 6), 3'(e % 6), 32'(((e - 1) / 6) % 16), 1'b1, 1'b0, 2'd0, 1'b1);
      tick();
    end

    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
